// File: rtl/apb_pkg.sv
// Shared APB completer types: FSM state encoding, response codes and the
// byte-strobe merge used when committing a write.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // Widest data bus the merge helper supports; callers zero-extend and truncate.
  localparam int MAX_DW = 256;

  function automatic logic [MAX_DW-1:0] strb_merge(
    input logic [MAX_DW-1:0]   cur,
    input logic [MAX_DW-1:0]   wdat,
    input logic [MAX_DW/8-1:0] strb
  );
    logic [MAX_DW-1:0] r;
    r = cur;
    for (int b = 0; b < MAX_DW/8; b++) begin
      if (strb[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_reg_decode.sv
// Combinational APB register decode: byte address to register index, plus
// the valid/error verdict for a captured transfer.
module apb_reg_decode #(
  parameter int                  AW_APB     = 32,
  parameter int                  DW_APB     = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [AW_APB-1:0]   BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter int                  PRIV_WRITE = 0
) (
  input  logic [AW_APB-1:0]           paddr_i,
  input  logic                        pwrite_i,
  input  logic                        pprot0_i,
  output logic [$clog2(NUM_REGS)-1:0] index_o,
  output logic                        valid_o,
  output logic                        err_o
);
  localparam int BYTES = DW_APB / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int IW    = $clog2(NUM_REGS);

  logic [AW_APB-1:0] offset;

  assign offset  = paddr_i - BASE_ADDR;
  assign index_o = offset[LB +: IW];
  assign valid_o = (paddr_i >= BASE_ADDR)
                && (offset < AW_APB'(NUM_REGS * BYTES))
                && ((paddr_i & AW_APB'(BYTES - 1)) == '0);

  // Writes are refused on read-only slots and, when privileged writes are
  // enforced, on non-privileged accesses.
  assign err_o = !valid_o
              || (pwrite_i && (RO_MASK[index_o] || ((PRIV_WRITE != 0) && !pprot0_i)));

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer exposing a bank of byte-strobed RW / live RO registers with
// configurable wait states and PSLVERR on bad accesses.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int                  AW_APB      = 32,
  parameter int                  DW_APB      = 32,
  parameter int                  NUM_REGS    = 16,
  parameter logic [AW_APB-1:0]   BASE_ADDR   = '0,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter int                  PRIV_WRITE  = 0
) (
  input  logic                         apb_clk,
  input  logic                         sys_aresetn,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [AW_APB-1:0]            paddr_i,
  input  logic [DW_APB-1:0]            pwdata_i,
  input  logic [DW_APB/8-1:0]          pstrb_i,
  input  logic [2:0]                   pprot_i,
  output logic                         pready_o,
  output logic [DW_APB-1:0]            prdata_o,
  output logic                         pslverr_o,
  input  logic [NUM_REGS*DW_APB-1:0]   ro_in,
  output logic [NUM_REGS*DW_APB-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_stb,
  output logic [NUM_REGS-1:0]          rd_stb
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = DW_APB / 8;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW_APB-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DW_APB-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]       pstrb_q, pstrb_d;
  logic                pprot0_q, pprot0_d;
  logic [DW_APB-1:0]   regs_q [NUM_REGS];
  logic [DW_APB-1:0]   regs_d [NUM_REGS];
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DW_APB-1:0]   prdata_q, prdata_d;
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
  logic [NUM_REGS-1:0] rd_stb_q, rd_stb_d;

  logic [DW_APB-1:0]   ro_w [NUM_REGS];
  logic [IW-1:0]       idx;
  logic                dec_valid;
  logic                dec_err;
  logic                unused_pprot;

  assign unused_pprot = ^pprot_i[2:1];

  apb_reg_decode #(
    .AW_APB    (AW_APB),
    .DW_APB    (DW_APB),
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .RO_MASK   (RO_MASK),
    .PRIV_WRITE(PRIV_WRITE)
  ) u_decode (
    .paddr_i (paddr_q),
    .pwrite_i(pwrite_q),
    .pprot0_i(pprot0_q),
    .index_o (idx),
    .valid_o (dec_valid),
    .err_o   (dec_err)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slices
    assign ro_w[g]                   = ro_in[g*DW_APB +: DW_APB];
    assign regs_o[g*DW_APB +: DW_APB] = RO_MASK[g] ? '0 : regs_q[g];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot0_d  = pprot0_q;
    regs_d    = regs_q;
    pready_d  = 1'b0;
    pslverr_d = RESP_OKAY;
    prdata_d  = '0;
    wr_stb_d  = '0;
    rd_stb_d  = '0;
    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          paddr_d  = paddr_i;
          pwrite_d = pwrite_i;
          pwdata_d = pwdata_i;
          pstrb_d  = pstrb_i;
          pprot0_d = pprot_i[0];
          cnt_d    = 4'(WAIT_STATES);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // Dropping psel abandons the transfer before anything is committed.
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d  = DONE;
            pready_d = 1'b1;
            if (dec_err) begin
              pslverr_d = RESP_ERR;
            end else if (pwrite_q) begin
              regs_d[idx]   = DW_APB'(strb_merge(MAX_DW'(regs_q[idx]), MAX_DW'(pwdata_q),
                                                 (MAX_DW/8)'(pstrb_q)));
              wr_stb_d[idx] = 1'b1;
            end else begin
              prdata_d      = RO_MASK[idx] ? ro_w[idx] : regs_q[idx];
              rd_stb_d[idx] = 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk) begin
    if (!sys_aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wr_stb_q  <= '0;
      rd_stb_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      regs_q    <= regs_d;
    end
  end

  // Captured transfer attributes are only consumed after a fresh setup phase.
  always_ff @(posedge apb_clk) begin
    paddr_q  <= paddr_d;
    pwrite_q <= pwrite_d;
    pwdata_q <= pwdata_d;
    pstrb_q  <= pstrb_d;
    pprot0_q <= pprot0_d;
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;
  assign wr_stb    = wr_stb_q;
  assign rd_stb    = rd_stb_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: one instance with no wait states,
// a RO slot and privileged writes, one with three wait states.
module tb_apb_slave_regbank;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        psel [2];
  logic        penable [2];
  logic        pwrite [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb [2];
  logic [2:0]  pprot [2];
  logic        pready [2];
  logic        pslverr [2];
  logic [31:0] prdata [2];
  logic [511:0] regs [2];
  logic [15:0] wr_stb [2];
  logic [15:0] rd_stb [2];
  logic [511:0] ro_in;

  int checks = 0;
  int errors = 0;

  apb_slave_regbank #(
    .AW_APB(32), .DW_APB(32), .NUM_REGS(16), .BASE_ADDR(32'h0000_1000),
    .WAIT_STATES(0), .RO_MASK(16'h0008), .PRIV_WRITE(1)
  ) dut0 (
    .apb_clk(clk), .sys_aresetn(rstn),
    .psel_i(psel[0]), .penable_i(penable[0]), .pwrite_i(pwrite[0]),
    .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .pstrb_i(pstrb[0]), .pprot_i(pprot[0]),
    .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0]),
    .ro_in(ro_in), .regs_o(regs[0]), .wr_stb(wr_stb[0]), .rd_stb(rd_stb[0])
  );

  apb_slave_regbank #(
    .AW_APB(32), .DW_APB(32), .NUM_REGS(16), .BASE_ADDR(32'h0000_0000),
    .WAIT_STATES(3), .RO_MASK(16'h0000), .PRIV_WRITE(0)
  ) dut1 (
    .apb_clk(clk), .sys_aresetn(rstn),
    .psel_i(psel[1]), .penable_i(penable[1]), .pwrite_i(pwrite[1]),
    .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .pstrb_i(pstrb[1]), .pprot_i(pprot[1]),
    .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1]),
    .ro_in(ro_in), .regs_o(regs[1]), .wr_stb(wr_stb[1]), .rd_stb(rd_stb[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Setup at one negedge, access from the next; returns at the pready cycle
  // with psel/penable still asserted. lat counts cycles from the setup cycle.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, output int lat,
                          output logic [31:0] rdata, output logic err,
                          output logic [15:0] wstb, output logic [15:0] rstb);
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb; pprot[d] = prot;
    @(negedge clk);
    penable[d] = 1'b1;
    lat = 1;
    while (pready[d] !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    rdata = prdata[d]; err = pslverr[d]; wstb = wr_stb[d]; rstb = rd_stb[d];
  endtask

  task automatic apb_idle(input int d);
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [15:0] ws, rs;
    logic        seen;

    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
    end
    ro_in = '0;
    ro_in[3*32 +: 32] = 32'h0000_CAFE;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(pready[0]), 32'd0);
    chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
    chk("rst_prdata", prdata[0], 32'd0);
    chk("rst_regs", 32'(regs[0] != '0), 32'd0);
    chk("rst_stb", 32'({wr_stb[0], rd_stb[0]}), 32'd0);
    rstn = 1'b1;

    // Zero wait states: full write, read back
    apb_xfer(0, 1'b1, 32'h1008, 32'hDEAD_BEEF, 4'hF, 3'b001, lat, rd, er, ws, rs);
    chk("w2_lat", 32'(lat), 32'd2);
    chk("w2_err", 32'(er), 32'd0);
    chk("w2_wstb", 32'(ws), 32'h0004);
    chk("w2_regs", regs[0][2*32 +: 32], 32'hDEAD_BEEF);
    apb_idle(0);
    chk("w2_wstb_once", 32'(wr_stb[0]), 32'd0);
    chk("w2_pready_off", 32'(pready[0]), 32'd0);
    apb_xfer(0, 1'b0, 32'h1008, 32'h0, 4'h0, 3'b001, lat, rd, er, ws, rs);
    chk("r2_data", rd, 32'hDEAD_BEEF);
    chk("r2_rstb", 32'(rs), 32'h0004);
    chk("r2_err", 32'(er), 32'd0);
    apb_idle(0);
    chk("r2_prdata_off", prdata[0], 32'd0);
    chk("r2_rstb_once", 32'(rd_stb[0]), 32'd0);

    // Byte strobes
    apb_xfer(0, 1'b1, 32'h1004, 32'h1122_3344, 4'hF, 3'b001, lat, rd, er, ws, rs);
    apb_xfer(0, 1'b1, 32'h1004, 32'hAABB_CCDD, 4'b0101, 3'b001, lat, rd, er, ws, rs);
    apb_xfer(0, 1'b0, 32'h1004, 32'h0, 4'h0, 3'b001, lat, rd, er, ws, rs);
    chk("strb_read", rd, 32'h11BB_33DD);
    chk("strb_regs", regs[0][1*32 +: 32], 32'h11BB_33DD);

    // Read-only slot
    apb_xfer(0, 1'b0, 32'h100C, 32'h0, 4'h0, 3'b001, lat, rd, er, ws, rs);
    chk("ro_read", rd, 32'h0000_CAFE);
    chk("ro_rstb", 32'(rs), 32'h0008);
    apb_xfer(0, 1'b1, 32'h100C, 32'h5555_5555, 4'hF, 3'b001, lat, rd, er, ws, rs);
    chk("ro_wr_err", 32'(er), 32'd1);
    chk("ro_wr_wstb", 32'(ws), 32'd0);
    chk("ro_wr_prdata", rd, 32'd0);
    chk("ro_regs_zero", regs[0][3*32 +: 32], 32'd0);
    apb_idle(0);
    ro_in[3*32 +: 32] = 32'h0000_1234;
    apb_xfer(0, 1'b0, 32'h100C, 32'h0, 4'h0, 3'b001, lat, rd, er, ws, rs);
    chk("ro_live", rd, 32'h0000_1234);

    // Error cases
    apb_xfer(0, 1'b0, 32'h1040, 32'h0, 4'h0, 3'b001, lat, rd, er, ws, rs);
    chk("oob_err", 32'(er), 32'd1);
    chk("oob_prdata", rd, 32'd0);
    chk("oob_rstb", 32'(rs), 32'd0);
    apb_xfer(0, 1'b1, 32'h1005, 32'hFFFF_FFFF, 4'hF, 3'b001, lat, rd, er, ws, rs);
    chk("unal_err", 32'(er), 32'd1);
    chk("unal_reg1", regs[0][1*32 +: 32], 32'h11BB_33DD);
    apb_xfer(0, 1'b1, 32'h1008, 32'h0BAD_0BAD, 4'hF, 3'b000, lat, rd, er, ws, rs);
    chk("priv_err", 32'(er), 32'd1);
    chk("priv_prdata", rd, 32'd0);
    chk("priv_wstb", 32'(ws), 32'd0);
    chk("priv_reg2", regs[0][2*32 +: 32], 32'hDEAD_BEEF);
    apb_xfer(0, 1'b0, 32'h0FFC, 32'h0, 4'h0, 3'b001, lat, rd, er, ws, rs);
    chk("below_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b1, 32'h1008, 32'hFFFF_FFFF, 4'h0, 3'b001, lat, rd, er, ws, rs);
    chk("nostrb_err", 32'(er), 32'd0);
    chk("nostrb_wstb", 32'(ws), 32'h0004);
    chk("nostrb_reg2", regs[0][2*32 +: 32], 32'hDEAD_BEEF);
    apb_idle(0);

    // Three wait states with a back-to-back read
    apb_xfer(1, 1'b1, 32'h0010, 32'h5A5A_5A5A, 4'hF, 3'b000, lat, rd, er, ws, rs);
    chk("ws3_w_lat", 32'(lat), 32'd5);
    chk("ws3_w_wstb", 32'(ws), 32'h0010);
    apb_xfer(1, 1'b0, 32'h0010, 32'h0, 4'h0, 3'b000, lat, rd, er, ws, rs);
    chk("ws3_r_lat", 32'(lat), 32'd5);
    chk("ws3_r_data", rd, 32'h5A5A_5A5A);
    apb_idle(1);
    chk("ws3_pready_once", 32'(pready[1]), 32'd0);

    // psel dropped in WAIT
    apb_xfer(1, 1'b1, 32'h0014, 32'h1234_5678, 4'hF, 3'b000, lat, rd, er, ws, rs);
    apb_idle(1);
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0014; pwdata[1] = 32'hFFFF_FFFF; pstrb[1] = 4'hF;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | pready[1] | pslverr[1] | (wr_stb[1] != '0);
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    chk("abort_reg5", regs[1][5*32 +: 32], 32'h1234_5678);
    apb_xfer(1, 1'b0, 32'h0014, 32'h0, 4'h0, 3'b000, lat, rd, er, ws, rs);
    chk("abort_next_lat", 32'(lat), 32'd5);
    chk("abort_next_data", rd, 32'h1234_5678);
    apb_idle(1);

    // Reset asserted in WAIT
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0018; pwdata[1] = 32'hFFFF_FFFF; pstrb[1] = 4'hF;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    chk("rstw_pready", 32'(pready[1]), 32'd0);
    chk("rstw_pslverr", 32'(pslverr[1]), 32'd0);
    chk("rstw_regs", 32'(regs[1] != '0), 32'd0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | pready[1] | pslverr[1] | (wr_stb[1] != '0);
    end
    chk("rstw_quiet", 32'(seen), 32'd0);
    apb_xfer(1, 1'b1, 32'h0018, 32'hC0FF_EE00, 4'hF, 3'b000, lat, rd, er, ws, rs);
    chk("rstw_next_lat", 32'(lat), 32'd5);
    chk("rstw_next_err", 32'(er), 32'd0);
    chk("rstw_next_reg6", regs[1][6*32 +: 32], 32'hC0FF_EE00);
    apb_idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
